// File: rtl/rc_envelope_vca.sv
// rc_envelope_vca: RC-style exponential attack/release envelope with a VCA
// stage. It sits between the square-wave oscillator and the mixer. State only
// advances on audio_clk_en strobes.
//
// Optional feature macro: RC_ENVELOPE_VCA_RETRIGGER_EN. When it is defined, a
// rising trigger edge seen in RELEASE or HOLD hard-restarts the envelope from
// zero. When it is undefined (the default), re-entry into ATTACK continues
// from the current env value.
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | env = 0, tone gated off
// ATTACK  | env charging toward FULL (32768)
// HOLD    | env = FULL, unity gain
// RELEASE | env discharging toward 0
module rc_envelope_vca #(
  parameter int  SIGNAL_FRACTION_WIDTH = 14,
  parameter int  SAMPLE_RATE           = 48000,
  parameter real ATTACK_TAU            = 0.01,
  parameter real RELEASE_TAU           = 0.1
) (
  input  logic               clk,
  input  logic               I_RSTn,
  input  logic               audio_clk_en,
  input  logic               trigger,
  input  logic signed [15:0] in,
  output logic signed [15:0] out,
  output logic               env_active
);

  localparam logic [15:0] FULL = 16'd32768;

  // Step coefficients. They are clamped in the real domain first, so extreme
  // time constants cannot overflow the integer conversion.
  localparam real KA_RAW = 65536.0 / (SAMPLE_RATE * ATTACK_TAU);
  localparam real KR_RAW = 65536.0 / (SAMPLE_RATE * RELEASE_TAU);
  localparam real KA_CLP = (KA_RAW < 1.0) ? 1.0 : ((KA_RAW > 65535.0) ? 65535.0 : KA_RAW);
  localparam real KR_CLP = (KR_RAW < 1.0) ? 1.0 : ((KR_RAW > 65535.0) ? 65535.0 : KR_RAW);
  localparam logic [15:0] K_A = 16'($rtoi(KA_CLP + 0.5));
  localparam logic [15:0] K_R = 16'($rtoi(KR_CLP + 0.5));

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic        [15:0] env_q, env_d;
  logic               trg_q, trg_d;
  logic signed [15:0] out_q, out_d;

  logic        [15:0] up_env;
  logic        [15:0] dn_env;
  logic signed [32:0] vca_prod;

  // One exponential step of env toward FULL (up=1) or toward 0 (up=0).
  // If the scaled step would round to zero it becomes a unit step, so env
  // always lands exactly on the target. An arithmetic shift never moves env
  // past the target because |diff*K/65536| < |diff| for K <= 65535.
  function automatic logic [15:0] env_step(input logic [15:0] env,
                                           input logic        up,
                                           input logic [15:0] k);
    logic signed [16:0] diff;
    logic signed [33:0] prod;
    logic signed [17:0] step;
    logic signed [17:0] sum;
    diff = up ? (17'sd32768 - $signed({1'b0, env})) : -$signed({1'b0, env});
    prod = $signed({{17{diff[16]}}, diff}) * $signed({18'b0, k});
    step = 18'(prod >>> 16);
    if ((diff != 17'sd0) && (step == 18'sd0)) begin
      step = diff[16] ? -18'sd1 : 18'sd1;
    end
    sum = $signed({2'b00, env}) + step;
    return 16'(sum);
  endfunction

  // Candidate envelope values for this strobe, plus the VCA product, which
  // uses the envelope value before this strobe's update.
  always_comb begin
    up_env   = env_step(env_q, 1'b1, K_A);
    dn_env   = env_step(env_q, 1'b0, K_R);
    vca_prod = $signed({{17{in[15]}}, in}) * $signed({17'b0, env_q});
  end

  // State register, envelope, trigger history and output sample.
  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state_q <= IDLE;
      env_q   <= 16'd0;
      trg_q   <= 1'b0;
      out_q   <= 16'sd0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
      trg_q   <= trg_d;
      out_q   <= out_d;
    end
  end

  // Next-state, envelope update and VCA output. All of these hold between strobes.
  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    trg_d   = trg_q;
    out_d   = out_q;
    if (audio_clk_en) begin
      trg_d = trigger;
      out_d = 16'(vca_prod >>> 15);
      case (state_q)
        IDLE: begin
          env_d = 16'd0;
          if (trigger) begin
            env_d   = up_env;
            state_d = (up_env == FULL) ? HOLD : ATTACK;
          end
        end
        ATTACK: begin
          if (!trigger) begin
            state_d = RELEASE;
          end else begin
            env_d   = up_env;
            state_d = (up_env == FULL) ? HOLD : ATTACK;
          end
        end
        HOLD: begin
          env_d = FULL;
          if (!trigger) begin
            env_d   = dn_env;
            state_d = (dn_env == 16'd0) ? IDLE : RELEASE;
          end
`ifdef RC_ENVELOPE_VCA_RETRIGGER_EN
          else if (!trg_q) begin
            env_d   = 16'd0;
            state_d = ATTACK;
          end
`endif
        end
        RELEASE: begin
          if (trigger) begin
`ifdef RC_ENVELOPE_VCA_RETRIGGER_EN
            if (!trg_q) begin
              env_d   = 16'd0;
              state_d = ATTACK;
            end else begin
              env_d   = up_env;
              state_d = (up_env == FULL) ? HOLD : ATTACK;
            end
`else
            env_d   = up_env;
            state_d = (up_env == FULL) ? HOLD : ATTACK;
`endif
          end else begin
            env_d   = dn_env;
            state_d = (dn_env == 16'd0) ? IDLE : RELEASE;
          end
        end
        default: begin
          state_d = IDLE;
          env_d   = 16'd0;
        end
      endcase
    end
  end

  assign out        = out_q;
  assign env_active = (state_q != IDLE);

endmodule

// File: tb/tb_rc_envelope_vca.sv
// Directed bench for rc_envelope_vca. It runs with ATTACK_TAU = RELEASE_TAU = 1/12000
// at 48 kHz, so both step coefficients equal 16384.
module tb_rc_envelope_vca;

  logic               clk;
  logic               I_RSTn;
  logic               audio_clk_en;
  logic               trigger;
  logic signed [15:0] in;
  logic signed [15:0] out;
  logic               env_active;

  int tests_run;
  int tests_failed;

  rc_envelope_vca #(
    .SIGNAL_FRACTION_WIDTH(14),
    .SAMPLE_RATE(48000),
    .ATTACK_TAU(1.0 / 12000.0),
    .RELEASE_TAU(1.0 / 12000.0)
  ) dut (
    .clk(clk),
    .I_RSTn(I_RSTn),
    .audio_clk_en(audio_clk_en),
    .trigger(trigger),
    .in(in),
    .out(out),
    .env_active(env_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One strobe: raise audio_clk_en for a single clk cycle, then sample 1 ns after the edge.
  task automatic strobe();
    @(negedge clk);
    audio_clk_en = 1'b1;
    @(posedge clk);
    #1;
    audio_clk_en = 1'b0;
  endtask

  int n;
  int prev;
  int reached;
  int mono;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    I_RSTn       = 1'b0;
    audio_clk_en = 1'b0;
    trigger      = 1'b0;
    in           = 16'sd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", int'(out), 0);
    check("reset_active", int'(env_active), 0);
    check("reset_env", int'(dut.env_q), 0);
    @(negedge clk);
    I_RSTn = 1'b1;

    // Attack from IDLE
    in      = 16'sd16384;
    trigger = 1'b1;
    strobe();
    check("atk0_env", int'(dut.env_q), 8192);
    check("atk0_out", int'(out), 0);
    check("atk0_active", int'(env_active), 1);
    strobe();
    check("atk1_env", int'(dut.env_q), 14336);
    check("atk1_out", int'(out), 4096);
    strobe();
    check("atk2_env", int'(dut.env_q), 18944);
    check("atk2_out", int'(out), 7168);

    // Convergence to FULL, then unity gain in HOLD
    n = 0;
    while (dut.env_q != 16'd32768 && n < 100) begin
      strobe();
      n++;
    end
    check("atk_converge", int'(dut.env_q), 32768);
    in = -16'sd32768;
    strobe();
    check("hold_env", int'(dut.env_q), 32768);
    check("hold_out_neg", int'(out), -32768);
    in = 16'sd32767;
    strobe();
    check("hold_out_pos", int'(out), 32767);
    check("hold_active", int'(env_active), 1);

    // Release from HOLD down to exactly 0
    trigger = 1'b0;
    strobe();
    check("rel0_env", int'(dut.env_q), 24576);
    strobe();
    check("rel1_env", int'(dut.env_q), 18432);
    prev    = int'(dut.env_q);
    reached = 0;
    mono    = 1;
    for (int i = 0; i < 200 && reached == 0; i++) begin
      strobe();
      if (int'(dut.env_q) > prev) mono = 0;
      prev = int'(dut.env_q);
      if (dut.env_q == 16'd0) begin
        reached = 1;
        check("rel_idle_active", int'(env_active), 0);
      end
    end
    check("rel_reached_zero", reached, 1);
    check("rel_monotonic", mono, 1);
    strobe();
    check("idle_out", int'(out), 0);

    // Strobe gating in IDLE: a short trigger pulse between strobes is ignored
    @(negedge clk);
    trigger = 1'b1;
    in      = 16'sd1000;
    @(negedge clk);
    trigger = 1'b0;
    repeat (2) @(negedge clk);
    check("gate_idle_env", int'(dut.env_q), 0);
    check("gate_idle_active", int'(env_active), 0);
    strobe();
    check("gate_idle_strobe_active", int'(env_active), 0);

    // Re-entry: attack to 14336, drop trigger, then raise it again
    in      = 16'sd16384;
    trigger = 1'b1;
    strobe();
    check("re_atk0_env", int'(dut.env_q), 8192);
    strobe();
    check("re_atk1_env", int'(dut.env_q), 14336);
    trigger = 1'b0;
    strobe();
    check("re_rel_env", int'(dut.env_q), 14336);
    check("re_rel_out", int'(out), 7168);
    check("re_rel_active", int'(env_active), 1);

    // Gating mid-envelope: trigger and in wiggle with no strobe present
    @(negedge clk);
    trigger = 1'b1;
    in      = -16'sd5000;
    @(negedge clk);
    trigger = 1'b0;
    in      = 16'sd123;
    repeat (2) @(negedge clk);
    check("gate_mid_env", int'(dut.env_q), 14336);
    check("gate_mid_out", int'(out), 7168);
    check("gate_mid_active", int'(env_active), 1);

    in      = 16'sd16384;
    trigger = 1'b1;
    strobe();
`ifdef RC_ENVELOPE_VCA_RETRIGGER_EN
    check("retrig_env", int'(dut.env_q), 0);
`else
    check("reentry_env", int'(dut.env_q), 18944);
`endif
    check("reentry_out", int'(out), 7168);
    strobe();
`ifdef RC_ENVELOPE_VCA_RETRIGGER_EN
    check("retrig_next_env", int'(dut.env_q), 8192);
`else
    check("reentry_next_env", int'(dut.env_q), 22400);
`endif

    // Asynchronous reset mid-attack
    strobe();
    @(negedge clk);
    I_RSTn = 1'b0;
    #1;
    check("async_rst_out", int'(out), 0);
    check("async_rst_active", int'(env_active), 0);
    check("async_rst_env", int'(dut.env_q), 0);
    @(negedge clk);
    I_RSTn  = 1'b1;
    trigger = 1'b0;
    strobe();
    strobe();
    check("post_rst_out", int'(out), 0);
    check("post_rst_active", int'(env_active), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rc_envelope_vca.md
# rc_envelope_vca

Sample-rate envelope generator and voltage-controlled amplifier placed directly downstream of the inverter square-wave oscillator in the discrete sound path. It models the RC charge/discharge gate that switches a tone on and off from a CPU sound-trigger latch. It multiplies the incoming signed 16-bit oscillator sample by an exponential attack/release envelope and passes the result to the mixer. All state advances only on `audio_clk_en`.

## Interface
- `SIGNAL_FRACTION_WIDTH`, 14: signal scaling; pass-through only, identical to the upstream oscillator.
- `SAMPLE_RATE`, 48000: audio strobe rate [Hz].
- `ATTACK_TAU`, 0.01: charge time constant R·C [s].
- `RELEASE_TAU`, 0.1: discharge time constant R·C [s].
- `clk  input  1`: system clock.
- `I_RSTn  input  1`: reset, asynchronous, active-low.
- `audio_clk_en  input  1`: one-`clk` sample strobe.
- `trigger  input  1`: sound-enable level, already synchronous to `clk`.
- `in  input  signed 16`: oscillator sample.
- `out  output  signed 16`: enveloped sample.
- `env_active  output  1`: high whenever state ≠ IDLE.

## Operation
- Envelope `env`: unsigned 16-bit Q1.15; 0 = silent, FULL = 32768 = unity gain.
- Step coefficients are localparams, computed and clamped to 1..65535:
  - K_A = round(65536 / (SAMPLE_RATE·ATTACK_TAU))
  - K_R = round(65536 / (SAMPLE_RATE·RELEASE_TAU))
- Update per strobe, with target T = FULL in ATTACK and 0 in RELEASE:
  - diff = T − env, 17-bit signed.
  - step = (diff·K) >>> 16, arithmetic.
  - If diff ≠ 0 and step == 0, step = sign(diff)·1. This guarantees exact convergence.
  - env ← env + step. Never overshoots T.
- State machine, evaluated only on `audio_clk_en`. `trigger` is sampled at the strobe; `trg_q` holds the previous strobe's sample.
  - IDLE: env = 0. trigger=1 → ATTACK.
  - ATTACK: env moves toward FULL. trigger=0 → RELEASE, same strobe, no step applied. env reaching FULL → HOLD.
  - HOLD: env = FULL. trigger=0 → RELEASE.
  - RELEASE: env moves toward 0. trigger=1 → ATTACK, starting from current env; see Configuration. env reaching 0 → IDLE.
- VCA, on each strobe: out ← (in · env_q) >>> 15.
  - env_q is the envelope value before this strobe's update.
  - The product is 33-bit signed. The result always fits in 16 bits because env ≤ FULL, so no saturation is needed.
- `trigger` changes between strobes are ignored. Only the value at the strobe counts.

## Timing
- Reset values: out = 0, env = 0, state = IDLE, env_active = 0, trg_q = 0.
- Reset mid-operation returns all of the above immediately and asynchronously.
- `out` and `env` update only on the `clk` edge where `audio_clk_en` = 1. They hold otherwise.
- Latency from `in` to `out`: 1 strobe.
- Gain latency: trigger sampled at strobe n changes env at n; that env first affects `out` at n+1.
- `env_active` is registered. It rises on the strobe that enters ATTACK and falls on the strobe that enters IDLE.
- Back-to-back strobes on consecutive `clk` cycles are legal.
- Simultaneous events:
  - trigger=0 in the same strobe that env would reach FULL: RELEASE wins.
  - trigger=1 in the same strobe that env would reach 0: ATTACK wins.

## Configuration
- `RC_ENVELOPE_VCA_RETRIGGER_EN` defined: a rising edge (trigger=1, trg_q=0) seen in RELEASE or HOLD forces env ← 0 and state ← ATTACK. This gives a hard restart click, matching a discharged-capacitor retrigger.
- Undefined: re-entry to ATTACK continues from the current env value with no discontinuity. This is the default build.

## Test plan
Tests use SAMPLE_RATE=48000 and ATTACK_TAU=RELEASE_TAU=1/12000, so K_A = K_R = 16384.

- **Reset:** assert I_RSTn=0 mid-ATTACK → out=0, env_active=0 on the same cycle; after release, out stays 0 with trigger=0.
- **Attack:** in=16384, trigger=1 from strobe 0 → env 8192, 14336, 18944; out 0, 4096, 7168.
- **Convergence:** hold trigger=1 → env reaches exactly 32768 and state HOLD; out then equals in (in=−32768 → out=−32768; in=32767 → 32767).
- **Release:** from HOLD drop trigger → env 24576, 18432, … reaches exactly 0; IDLE and env_active=0 on that strobe; no negative env.
- **Re-entry:** trigger 1→0→1 with env=14336 in RELEASE → next env steps up from the decayed value (default build); with `RC_ENVELOPE_VCA_RETRIGGER_EN` defined, env = 0 at the retrigger strobe, then 8192.
- **Strobe gating:** toggle trigger and `in` between strobes with `audio_clk_en`=0 → out, env, and state unchanged; a 1-cycle trigger pulse not aligned to a strobe has no effect.
